// File: rtl/ahb_sram_pkg.sv
// Shared constants, state encoding and byte-lane helper for the AHB-Lite SRAM controller.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_WAIT = 3'd1,
        ST_W_DATA = 3'd2,
        ST_R_WAIT = 3'd3,
        ST_R_ACC  = 3'd4,
        ST_R_DATA = 3'd5,
        ST_ERR1   = 3'd6,
        ST_ERR2   = 3'd7
    } state_t;

    function automatic logic trans_active(input logic [1:0] trans);
        logic active;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

    // Lanes are computed for up to 8 bytes; callers truncate to their bus width.
    function automatic logic [7:0] byte_lanes(input logic [2:0] size, input logic [2:0] lane_off);
        logic [7:0] base;
        case (size)
            HSIZE_BYTE:  base = 8'h01;
            HSIZE_HALF:  base = 8'h03;
            HSIZE_WORD:  base = 8'h0F;
            HSIZE_DWORD: base = 8'hFF;
            default:     base = 8'h00;
        endcase
        return base << lane_off;
    endfunction

endpackage

// File: rtl/ahb_sram_wait_cnt.sv
// Loadable down-counter used to time data-phase wait states; done is high at zero.
module ahb_sram_wait_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] cnt_r;

    // Count register: load wins over decrement, and the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {WIDTH{1'b0}})) begin
            cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/ahb_sram_controller_p.sv
// AHB-Lite slave in front of a single-port synchronous SRAM with sized writes,
// programmable wait states, pipelined address/data phases and ERROR responses.
module ahb_sram_controller_p
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                                          hclk,
    input  logic                                          hreset,
    input  logic                                          hsel,
    input  logic [ADDR_WIDTH-1:0]                         haddr,
    input  logic [1:0]                                    htrans,
    input  logic                                          hwrite,
    input  logic [2:0]                                    hsize,
    input  logic [DATA_WIDTH-1:0]                         hwdata,
    input  logic                                          hready,
    output logic                                          hreadyout,
    output logic                                          hresp,
    output logic [DATA_WIDTH-1:0]                         hrdata,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]                         sram_din,
    input  logic [DATA_WIDTH-1:0]                         sram_dout,
    output logic                                          sram_ce,
    output logic                                          sram_we,
    output logic [DATA_WIDTH/8-1:0]                       sram_be
);

    localparam int         BYTES     = DATA_WIDTH / 8;
    localparam int         LANE_BITS = $clog2(BYTES);
    localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);
    localparam logic [2:0] LANE_MASK = 3'(BYTES - 1);
    localparam bit         HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                  state_r;
    state_t                  state_next_s;
    state_t                  first_state_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    write_r;
    logic [2:0]              size_r;
    logic [ADDR_WIDTH-1:0]   align_mask_s;
    logic                    illegal_s;
    logic                    final_s;
    logic                    accept_s;
    logic                    wait_dec_s;
    logic                    wait_done_s;
    logic [2:0]              lane_off_s;

    assign align_mask_s = ADDR_WIDTH'((32'd1 << hsize) - 32'd1);
    assign illegal_s    = (hsize > MAX_SIZE) || ((haddr & align_mask_s) != {ADDR_WIDTH{1'b0}});
    // A new address phase is only taken in a cycle that ends the current data phase.
    assign final_s      = (state_r == ST_IDLE) || (state_r == ST_W_DATA) ||
                          (state_r == ST_R_DATA) || (state_r == ST_ERR2);
    assign accept_s     = final_s && hsel && hready && trans_active(htrans);
    assign wait_dec_s   = (state_r == ST_W_WAIT) || (state_r == ST_R_WAIT);
    assign lane_off_s   = addr_r[2:0] & LANE_MASK;
    assign sram_addr    = addr_r[ADDR_WIDTH-1:LANE_BITS];

    ahb_sram_wait_cnt #(.WIDTH(4)) u_wait_cnt (
        .clk      (hclk),
        .rst      (hreset),
        .load     (accept_s),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec_s),
        .done     (wait_done_s)
    );

    // State register and address-phase capture.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            write_r <= 1'b0;
            size_r  <= 3'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                addr_r  <= haddr;
                write_r <= hwrite;
                size_r  <= hsize;
            end else begin
                addr_r  <= addr_r;
                write_r <= write_r;
                size_r  <= size_r;
            end
        end
    end

    // First data-phase state of a freshly accepted transfer.
    always_comb begin
        first_state_s = ST_IDLE;
        if (illegal_s) begin
            first_state_s = ST_ERR1;
        end else if (hwrite) begin
            first_state_s = HAS_WAIT ? ST_W_WAIT : ST_W_DATA;
        end else begin
            first_state_s = HAS_WAIT ? ST_R_WAIT : ST_R_ACC;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_W_DATA, ST_R_DATA, ST_ERR2: begin
                if (accept_s) begin
                    state_next_s = first_state_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_W_WAIT: begin
                if (wait_done_s) begin
                    state_next_s = ST_W_DATA;
                end else begin
                    state_next_s = ST_W_WAIT;
                end
            end
            ST_R_WAIT: begin
                if (wait_done_s) begin
                    state_next_s = ST_R_ACC;
                end else begin
                    state_next_s = ST_R_WAIT;
                end
            end
            ST_R_ACC: state_next_s = ST_R_DATA;
            ST_ERR1:  state_next_s = ST_ERR2;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Bus and SRAM outputs decoded from the state register.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = {DATA_WIDTH{1'b0}};
        sram_ce   = 1'b0;
        sram_we   = 1'b0;
        sram_be   = {BYTES{1'b0}};
        sram_din  = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: hreadyout = 1'b1;
            ST_W_WAIT, ST_R_WAIT: hreadyout = 1'b0;
            ST_W_DATA: begin
                sram_ce  = 1'b1;
                sram_we  = write_r;
                sram_din = hwdata;
                sram_be  = BYTES'(byte_lanes(size_r, lane_off_s));
            end
            ST_R_ACC: begin
                hreadyout = 1'b0;
                sram_ce   = 1'b1;
            end
            ST_R_DATA: hrdata = sram_dout;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: hreadyout = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_controller_p.sv
// Directed bench: a pipelined AHB master drives two controllers (0 and 3 wait states),
// a transaction-level model predicts every output cycle, and literal checks pin the model.
module tb_ahb_sram_controller_p;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        logic [9:0]  addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic [1:0]  hsel_v;
    logic [9:0]  haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        sel;
    logic        hready_bus;
    logic [1:0]  rdy_v, resp_v, ce_v, we_v;
    logic [31:0] rdata_v [2];
    logic [31:0] din_v [2];
    logic [31:0] dout_v [2];
    logic [7:0]  saddr_v [2];
    logic [3:0]  be_v [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign hready_bus = rdy_v[sel];

    ahb_sram_controller_p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut0 (
        .hclk(clk), .hreset(hreset), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus),
        .hreadyout(rdy_v[0]), .hresp(resp_v[0]), .hrdata(rdata_v[0]), .sram_addr(saddr_v[0]),
        .sram_din(din_v[0]), .sram_dout(dout_v[0]), .sram_ce(ce_v[0]), .sram_we(we_v[0]),
        .sram_be(be_v[0]));

    ahb_sram_controller_p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3)) dut3 (
        .hclk(clk), .hreset(hreset), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready_bus),
        .hreadyout(rdy_v[1]), .hresp(resp_v[1]), .hrdata(rdata_v[1]), .sram_addr(saddr_v[1]),
        .sram_din(din_v[1]), .sram_dout(dout_v[1]), .sram_ce(ce_v[1]), .sram_we(we_v[1]),
        .sram_be(be_v[1]));

    // SRAM macros behind each controller.
    logic [31:0] sram_mem [2][256];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ce_v[k] === 1'b1) begin
                if (we_v[k] === 1'b1) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_v[k][b]) begin
                            sram_mem[k][saddr_v[k]][8*b +: 8] <= din_v[k][8*b +: 8];
                        end
                    end
                end else begin
                    dout_v[k] <= sram_mem[k][saddr_v[k]];
                end
            end
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  ref_mem [2][1024];
    int          ws_of [2] = '{0, 3};
    int          m_kind [2] = '{0, 0};   // 0 none, 1 write, 2 read, 3 error
    int          m_pos [2] = '{0, 0};
    int          m_addr [2] = '{0, 0};
    int          m_size [2] = '{0, 0};
    bit          p_rdy [2] = '{1'b0, 1'b0};
    bit          p_acc [2] = '{1'b0, 1'b0};
    bit          p_write [2] = '{1'b0, 1'b0};
    int          p_addr [2] = '{0, 0};
    int          p_size [2] = '{0, 0};
    bit          started [2] = '{1'b0, 1'b0};
    bit          p_rst = 1'b0;
    logic [3:0]  last_be [2];
    logic [7:0]  last_waddr [2];
    int          ce_cnt [2] = '{0, 0};
    logic        e_rdy, e_resp, e_ce, e_last;
    logic [31:0] e_rd;
    logic [3:0]  e_be;

    function automatic logic [31:0] ref_word(input int k, input int a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[k][(a & ~3) + b];
        return w;
    endfunction

    // Compare process: every cycle, derive what each DUT must show from the transfer in flight.
    always begin
        @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            if (p_rst) begin
                m_kind[k] = 0;
                started[k] = 1'b1;
            end else if (p_rdy[k]) begin
                if (p_acc[k]) begin
                    m_pos[k] = 0;
                    m_addr[k] = p_addr[k];
                    m_size[k] = p_size[k];
                    if (p_size[k] > 2 || (p_addr[k] % (1 << p_size[k])) != 0) m_kind[k] = 3;
                    else m_kind[k] = p_write[k] ? 1 : 2;
                end else begin
                    m_kind[k] = 0;
                end
            end else begin
                m_pos[k] = m_pos[k] + 1;
            end
            e_rdy = 1'b1; e_resp = 1'b0; e_ce = 1'b0; e_last = 1'b0; e_rd = 32'd0;
            case (m_kind[k])
                1: begin
                    e_last = (m_pos[k] == ws_of[k]);
                    e_rdy = e_last;
                    e_ce = e_last;
                end
                2: begin
                    e_last = (m_pos[k] == ws_of[k] + 1);
                    e_rdy = e_last;
                    e_ce = (m_pos[k] == ws_of[k]);
                    if (e_last) e_rd = ref_word(k, m_addr[k]);
                end
                3: begin
                    e_rdy = (m_pos[k] == 1);
                    e_resp = 1'b1;
                end
                default: e_rdy = 1'b1;
            endcase
            if (started[k]) begin
                chk32($sformatf("dut%0d hreadyout", k), 32'(rdy_v[k]), 32'(e_rdy));
                chk32($sformatf("dut%0d hresp", k), 32'(resp_v[k]), 32'(e_resp));
                chk32($sformatf("dut%0d sram_ce", k), 32'(ce_v[k]), 32'(e_ce));
                chk32($sformatf("dut%0d hrdata", k), rdata_v[k], e_rd);
                if (e_ce) begin
                    chk32($sformatf("dut%0d sram_we", k), 32'(we_v[k]), 32'(m_kind[k] == 1));
                    chk32($sformatf("dut%0d sram_addr", k), 32'(saddr_v[k]), 32'(m_addr[k] >> 2));
                end
                if (m_kind[k] == 1 && e_last) begin
                    e_be = 4'd0;
                    for (int i = 0; i < (1 << m_size[k]); i++) e_be[(m_addr[k] + i) % 4] = 1'b1;
                    chk32($sformatf("dut%0d sram_be", k), 32'(be_v[k]), 32'(e_be));
                    chk32($sformatf("dut%0d sram_din", k), din_v[k], hwdata);
                    for (int i = 0; i < (1 << m_size[k]); i++)
                        ref_mem[k][m_addr[k] + i] = hwdata[8*((m_addr[k] + i) % 4) +: 8];
                end
                if (ce_v[k] === 1'b1) begin
                    ce_cnt[k]++;
                    if (we_v[k] === 1'b1) begin
                        last_be[k] = be_v[k];
                        last_waddr[k] = saddr_v[k];
                    end
                end
            end
            p_rdy[k] = e_rdy;
            p_acc[k] = hsel_v[k] && htrans[1] && hready_bus;
            p_write[k] = hwrite;
            p_addr[k] = int'(haddr);
            p_size[k] = int'(hsize);
        end
        p_rst = hreset;
    end

    // ---------------- pipelined AHB master ----------------
    xfer_t       xq [$];
    logic [31:0] rdq [$];
    int          stall_cnt, resp_cnt;

    function automatic xfer_t mk(input logic [9:0] a, input logic w, input logic [2:0] s,
                                 input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.write = w; x.size = s; x.wdata = d;
        return x;
    endfunction

    task automatic drive_addr(input bit v, input xfer_t a);
        if (v) begin
            hsel_v = sel ? 2'b10 : 2'b01;
            htrans = 2'b10;
            haddr = a.addr;
            hwrite = a.write;
            hsize = a.size;
        end else begin
            hsel_v = 2'b00;
            htrans = 2'b00;
        end
    endtask

    // Runs everything in xq back to back; called and returns at posedge+1.
    task automatic run_xfers();
        bit have_a, have_d;
        logic rdy;
        xfer_t a, d;
        int cyc;
        cyc = 0;
        stall_cnt = 0;
        resp_cnt = 0;
        rdq.delete();
        have_d = 1'b0;
        a = mk(10'd0, 1'b0, 3'd0, 32'd0);
        d = a;
        have_a = (xq.size() > 0);
        if (have_a) a = xq.pop_front();
        drive_addr(have_a, a);
        hwdata = 32'd0;
        while ((have_a || have_d) && cyc < 200) begin
            #2;
            rdy = hready_bus;
            if (have_d) begin
                if (resp_v[sel] === 1'b1) resp_cnt++;
                if (rdy !== 1'b1) stall_cnt++;
                else if (!d.write) rdq.push_back(rdata_v[sel]);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rdy === 1'b1) begin
                have_d = have_a;
                d = a;
                have_a = (xq.size() > 0);
                if (have_a) a = xq.pop_front();
            end
            drive_addr(have_a, a);
            hwdata = (have_d && d.write) ? d.wdata : 32'd0;
        end
        chk32("xfer_budget", 32'(have_a || have_d), 32'd0);
    endtask

    task automatic chk_rd(input string name, input logic [31:0] exp);
        logic [31:0] v;
        v = (rdq.size() > 0) ? rdq[0] : 32'hxxxx_xxxx;
        chk32(name, v, exp);
    endtask

    int ce_before;

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = 8'd0;
        sel = 1'b0;
        hreset = 1'b1;
        hsel_v = 2'b00; haddr = 10'd0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk32("rst hreadyout", 32'(rdy_v[0]), 32'd1);
        chk32("rst hresp", 32'(resp_v[0]), 32'd0);
        chk32("rst sram_ce", 32'(ce_v[0]), 32'd0);
        chk32("rst sram_we", 32'(we_v[0]), 32'd0);
        chk32("rst hrdata", rdata_v[0], 32'd0);
        chk32("rst ws3 hreadyout", 32'(rdy_v[1]), 32'd1);
        hreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk32("idle hreadyout", 32'(rdy_v[0]), 32'd1);
        chk32("idle sram_ce", 32'(ce_v[0]), 32'd0);
        chk32("idle sram_addr", 32'(saddr_v[0]), 32'd0);

        // Word write then read, no wait states.
        xq.push_back(mk(10'h010, 1'b1, 3'd2, 32'hDEADBEEF));
        run_xfers();
        chk32("ws0 write stalls", 32'(stall_cnt), 32'd0);
        chk32("ws0 write addr", 32'(last_waddr[0]), 32'd4);
        chk32("ws0 write be", 32'(last_be[0]), 32'hF);
        xq.push_back(mk(10'h010, 1'b0, 3'd2, 32'd0));
        run_xfers();
        chk32("ws0 read stalls", 32'(stall_cnt), 32'd1);
        chk_rd("ws0 read data", 32'hDEADBEEF);

        // Byte write into the top lane.
        xq.push_back(mk(10'h013, 1'b1, 3'd0, 32'hAA000000));
        run_xfers();
        chk32("byte write be", 32'(last_be[0]), 32'h8);
        xq.push_back(mk(10'h010, 1'b0, 3'd2, 32'd0));
        run_xfers();
        chk_rd("byte merge read", 32'hAAADBEEF);

        // Back-to-back write then read of the same word.
        xq.push_back(mk(10'h020, 1'b1, 3'd2, 32'h12345678));
        xq.push_back(mk(10'h020, 1'b0, 3'd2, 32'd0));
        run_xfers();
        chk32("b2b stalls", 32'(stall_cnt), 32'd1);
        chk_rd("b2b read data", 32'h12345678);
        xq.push_back(mk(10'h022, 1'b1, 3'd1, 32'hBEEF0000));
        xq.push_back(mk(10'h020, 1'b0, 3'd2, 32'd0));
        run_xfers();
        chk32("half write be", 32'(last_be[0]), 32'hC);
        chk_rd("half merge read", 32'hBEEF5678);

        // Three wait states.
        sel = 1'b1;
        xq.push_back(mk(10'h040, 1'b1, 3'd2, 32'hCAFEF00D));
        run_xfers();
        chk32("ws3 write stalls", 32'(stall_cnt), 32'd3);
        chk32("ws3 write addr", 32'(last_waddr[1]), 32'h10);
        xq.push_back(mk(10'h040, 1'b0, 3'd2, 32'd0));
        run_xfers();
        chk32("ws3 read stalls", 32'(stall_cnt), 32'd4);
        chk_rd("ws3 read data", 32'hCAFEF00D);

        // Illegal transfers: misaligned halfword and oversize.
        sel = 1'b0;
        ce_before = ce_cnt[0];
        xq.push_back(mk(10'h001, 1'b0, 3'd1, 32'd0));
        run_xfers();
        chk32("misalign resp cycles", 32'(resp_cnt), 32'd2);
        chk32("misalign stalls", 32'(stall_cnt), 32'd1);
        xq.push_back(mk(10'h000, 1'b1, 3'd3, 32'h55555555));
        run_xfers();
        chk32("oversize resp cycles", 32'(resp_cnt), 32'd2);
        chk32("error no sram access", 32'(ce_cnt[0] - ce_before), 32'd0);

        // Reset while in the read wait states.
        sel = 1'b1;
        hsel_v = 2'b10; haddr = 10'h010; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        @(posedge clk);
        #1;
        chk32("rwait hreadyout", 32'(rdy_v[1]), 32'd0);
        htrans = 2'b00;
        hsel_v = 2'b00;
        hreset = 1'b1;
        @(posedge clk);
        #1;
        hreset = 1'b0;
        chk32("mid rst hreadyout", 32'(rdy_v[1]), 32'd1);
        chk32("mid rst sram_ce", 32'(ce_v[1]), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
